// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the multiplexed HH:MM display scanner.
package clock_disp_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        GAP   = 2'd1,
        DRIVE = 2'd2
    } disp_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [1:0] HR_T  = 2'd0;
    localparam logic [1:0] HR_U  = 2'd1;
    localparam logic [1:0] MIN_T = 2'd2;
    localparam logic [1:0] MIN_U = 2'd3;

    // True when the captured digits cannot form a valid 24-hour HH:MM time.
    function automatic logic time_invalid(input logic [2:0] ht, input logic [3:0] hu,
                                          input logic [2:0] mt, input logic [3:0] mu);
        return (ht > 3'd2) || (hu > 4'd9) || (mt > 3'd5) || (mu > 4'd9) ||
               ((ht == 3'd2) && (hu > 4'd3));
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Active-low BCD to 7-segment decoder {a,b,c,d,e,f,g}; values above 9 show a dash.
module bcd_to_seg7
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        unique case (bcd)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Scans four snapshotted BCD time digits onto a common-anode 4-digit display
// with an inter-digit blank gap, a blinking colon and a sticky bad-digit flag.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 4,
    parameter int BLINK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] hr_tens,
    input  logic [3:0] hr_units,
    input  logic [2:0] min_tens,
    input  logic [3:0] min_units,
    input  logic       blank_lead,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done,
    output logic       err
);

    localparam int CNT_W   = $clog2(REFRESH_DIV);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(REFRESH_DIV - 2);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    disp_state_e        state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         shadow_q [4];
    logic               lead_blank_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               colon_on_q;
    logic               err_q;
    logic               capture;
    logic               frame_end;
    logic               blank_digit;
    logic [6:0]         seg_code;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            idx_q   <= HR_T;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path through
    // the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            LOAD: begin
                capture = 1'b1;
                idx_d   = HR_T;
                state_d = GAP;
            end
            GAP: begin
                cnt_d   = '0;
                state_d = DRIVE;
            end
            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = GAP;
                    if (idx_q == MIN_U) begin
                        idx_d     = HR_T;
                        capture   = 1'b1;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // NOTE: shadow is a small register array rather than a RAM, so it takes the
    // async reset like any other flop and the display never shows garbage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
            lead_blank_q <= 1'b0;
            blink_cnt_q  <= '0;
            colon_on_q   <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            if (capture) begin
                shadow_q[HR_T]  <= {1'b0, hr_tens};
                shadow_q[HR_U]  <= hr_units;
                shadow_q[MIN_T] <= {1'b0, min_tens};
                shadow_q[MIN_U] <= min_units;
                lead_blank_q    <= blank_lead;
                err_q           <= err_q | time_invalid(hr_tens, hr_units, min_tens, min_units);
            end
            if (frame_end) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q <= '0;
                    colon_on_q  <= ~colon_on_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (shadow_q[idx_q]),
        .seg (seg_code)
    );

    // blank_lead is snapshotted with the digits so outputs stay purely registered.
    assign blank_digit = lead_blank_q && (idx_q == HR_T) && (shadow_q[HR_T] == 4'd0);

    always_comb begin
        an  = 4'b1111;
        seg = SEG_BLANK;
        dp  = 1'b1;
        if (state_q == DRIVE && !blank_digit) begin
            an  = ~(4'b1000 >> idx_q);
            seg = seg_code;
            dp  = ~((idx_q == HR_U) && colon_on_q);
        end
    end

    assign frame_done = (state_q == DRIVE) && (idx_q == MIN_U) && (cnt_q == CNT_LAST);
    assign err        = err_q;

endmodule
